// File: rtl/stream_fetch_arbiter.sv
// Round-robin fetch arbiter: three operand streams share one synchronous-read memory port.
// Optional per-stream stall counters are built when FETCH_STATS_EN is defined.
module stream_fetch_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned IFM_BASE   = 0,
    parameter int unsigned IFM_LEN    = 154587,
    parameter int unsigned WGT_BASE   = 154587,
    parameter int unsigned WGT_LEN    = 34848,
    parameter int unsigned WGT1_BASE  = 189435,
    parameter int unsigned WGT1_LEN   = 614400
) (
    input  logic                  clk2,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  req_ifm,
    input  logic                  req_wgt,
    input  logic                  req_wgt1,
    output logic                  gnt_ifm,
    output logic                  gnt_wgt,
    output logic                  gnt_wgt1,
    output logic                  vld_ifm,
    output logic                  vld_wgt,
    output logic                  vld_wgt1,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wrap_ifm,
    output logic                  wrap_wgt,
    output logic                  wrap_wgt1,
    output logic                  busy,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]           stall_ifm,
    output logic [31:0]           stall_wgt,
    output logic [31:0]           stall_wgt1
`endif
);

    localparam logic [ADDR_WIDTH-1:0] IFM_BASE_A  = ADDR_WIDTH'(IFM_BASE);
    localparam logic [ADDR_WIDTH-1:0] WGT_BASE_A  = ADDR_WIDTH'(WGT_BASE);
    localparam logic [ADDR_WIDTH-1:0] WGT1_BASE_A = ADDR_WIDTH'(WGT1_BASE);
    localparam logic [ADDR_WIDTH-1:0] IFM_LAST    = ADDR_WIDTH'(IFM_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] WGT_LAST    = ADDR_WIDTH'(WGT_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] WGT1_LAST   = ADDR_WIDTH'(WGT1_LEN - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_nxt;
    logic                    arb_en;
    logic                    clr_off;
    logic [1:0]              rr_ptr;
    logic [2:0]              req_vec;
    logic [2:0]              gnt_p0;
    logic [2:0]              at_last;
    logic [2:0]              vld_p1;
    logic [2:0]              wrap_p1;
    logic [ADDR_WIDTH-1:0]   off_ifm;
    logic [ADDR_WIDTH-1:0]   off_wgt;
    logic [ADDR_WIDTH-1:0]   off_wgt1;

    function automatic logic [ADDR_WIDTH-1:0] step_off(
        input logic [ADDR_WIDTH-1:0] off,
        input logic [ADDR_WIDTH-1:0] last
    );
        return (off == last) ? '0 : off + ADDR_WIDTH'(1);
    endfunction

    assign req_vec = {req_wgt1, req_wgt, req_ifm};
    assign at_last = {off_wgt1 == WGT1_LAST, off_wgt == WGT_LAST, off_ifm == IFM_LAST};

    // Control: start/abort cycles never grant; abort dominates start.
    always_comb begin
        state_nxt = state_q;
        arb_en    = 1'b0;
        clr_off   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_RUN;
                    clr_off   = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    clr_off = 1'b1;
                end else begin
                    arb_en = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: round-robin search starting just after the last served stream.
    always_comb begin
        gnt_p0 = 3'b000;
        if (arb_en) begin
            case (rr_ptr)
                2'd0: begin
                    if (req_vec[1])      gnt_p0 = 3'b010;
                    else if (req_vec[2]) gnt_p0 = 3'b100;
                    else if (req_vec[0]) gnt_p0 = 3'b001;
                end
                2'd1: begin
                    if (req_vec[2])      gnt_p0 = 3'b100;
                    else if (req_vec[0]) gnt_p0 = 3'b001;
                    else if (req_vec[1]) gnt_p0 = 3'b010;
                end
                default: begin
                    if (req_vec[0])      gnt_p0 = 3'b001;
                    else if (req_vec[1]) gnt_p0 = 3'b010;
                    else if (req_vec[2]) gnt_p0 = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        case (gnt_p0)
            3'b001:  mem_addr = IFM_BASE_A + off_ifm;
            3'b010:  mem_addr = WGT_BASE_A + off_wgt;
            3'b100:  mem_addr = WGT1_BASE_A + off_wgt1;
            default: mem_addr = '0;
        endcase
    end

    // Stage p1: grant registered as data-valid, last-word issue registered as wrap.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr   <= 2'd2;
            off_ifm  <= '0;
            off_wgt  <= '0;
            off_wgt1 <= '0;
            vld_p1   <= 3'b000;
            wrap_p1  <= 3'b000;
        end else begin
            state_q <= state_nxt;
            vld_p1  <= gnt_p0;
            wrap_p1 <= gnt_p0 & at_last;
            if (gnt_p0[0]) rr_ptr <= 2'd0;
            if (gnt_p0[1]) rr_ptr <= 2'd1;
            if (gnt_p0[2]) rr_ptr <= 2'd2;
            if (clr_off) begin
                off_ifm  <= '0;
                off_wgt  <= '0;
                off_wgt1 <= '0;
            end else begin
                if (gnt_p0[0]) off_ifm  <= step_off(off_ifm, IFM_LAST);
                if (gnt_p0[1]) off_wgt  <= step_off(off_wgt, WGT_LAST);
                if (gnt_p0[2]) off_wgt1 <= step_off(off_wgt1, WGT1_LAST);
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stall_q [3];

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) stall_q[i] <= '0;
        end else if (clr_off) begin
            for (int i = 0; i < 3; i++) stall_q[i] <= '0;
        end else if (state_q == ST_RUN) begin
            for (int i = 0; i < 3; i++) begin
                if (req_vec[i] && !gnt_p0[i]) stall_q[i] <= sat_inc(stall_q[i]);
            end
        end
    end

    assign stall_ifm  = stall_q[0];
    assign stall_wgt  = stall_q[1];
    assign stall_wgt1 = stall_q[2];
`endif

    assign gnt_ifm   = gnt_p0[0];
    assign gnt_wgt   = gnt_p0[1];
    assign gnt_wgt1  = gnt_p0[2];
    assign mem_rd_en = |gnt_p0;
    assign vld_ifm   = vld_p1[0];
    assign vld_wgt   = vld_p1[1];
    assign vld_wgt1  = vld_p1[2];
    assign wrap_ifm  = wrap_p1[0];
    assign wrap_wgt  = wrap_p1[1];
    assign wrap_wgt1 = wrap_p1[2];
    assign busy      = (state_q == ST_RUN);
    assign rd_data   = mem_rd_data;

endmodule

// File: tb/tb_stream_fetch_arbiter.sv
// Bench for stream_fetch_arbiter: per-cycle reference model plus directed literal checks.
// The layer-1 weight stream is shortened to 4 words so its wrap is reachable.
module tb_stream_fetch_arbiter;

    localparam int WGT_LEN_TB = 4;

    logic        clk2 = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic        req_ifm, req_wgt, req_wgt1;
    logic        gnt_ifm, gnt_wgt, gnt_wgt1;
    logic        vld_ifm, vld_wgt, vld_wgt1;
    logic        wrap_ifm, wrap_wgt, wrap_wgt1;
    logic        busy, mem_rd_en;
    logic [15:0] rd_data;
    logic [19:0] mem_addr;
    logic [15:0] mem_rd_data = '0;
`ifdef FETCH_STATS_EN
    logic [31:0] stall_ifm, stall_wgt, stall_wgt1;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    stream_fetch_arbiter #(.WGT_LEN(WGT_LEN_TB)) dut (
        .clk2(clk2), .rst_n(rst_n), .start(start), .abort(abort),
        .req_ifm(req_ifm), .req_wgt(req_wgt), .req_wgt1(req_wgt1),
        .gnt_ifm(gnt_ifm), .gnt_wgt(gnt_wgt), .gnt_wgt1(gnt_wgt1),
        .vld_ifm(vld_ifm), .vld_wgt(vld_wgt), .vld_wgt1(vld_wgt1),
        .rd_data(rd_data),
        .wrap_ifm(wrap_ifm), .wrap_wgt(wrap_wgt), .wrap_wgt1(wrap_wgt1),
        .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data)
`ifdef FETCH_STATS_EN
        , .stall_ifm(stall_ifm), .stall_wgt(stall_wgt), .stall_wgt1(stall_wgt1)
`endif
    );

    always #5 clk2 = ~clk2;

    // Synchronous-read memory whose contents equal the word address.
    always @(posedge clk2) if (mem_rd_en) mem_rd_data <= mem_addr[15:0];

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stream bases/lengths and the arbitration rules in plain arithmetic.
    int          base [3] = '{0, 154587, 189435};
    int          len  [3] = '{154587, WGT_LEN_TB, 614400};
    int          m_off [3];
    int          m_ptr;
    bit          m_run;
    logic [2:0]  m_vld, m_wrap;
    logic [15:0] m_rd;
    longint      m_stall [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_off[i] = 0;
            m_stall[i] = 0;
        end
        m_ptr = 2; m_run = 0; m_vld = 0; m_wrap = 0; m_rd = 0;
    endtask

    initial model_reset();

    always @(negedge clk2) begin
        logic [2:0] req_v, exp_g;
        int         idx, j;
        longint     exp_addr;
        if (!rst_n) model_reset();
        req_v = {req_wgt1, req_wgt, req_ifm};
        exp_g = 0; idx = -1; exp_addr = 0;
        if (m_run && !start && !abort) begin
            for (int k = 1; k <= 3; k++) begin
                j = (m_ptr + k) % 3;
                if (idx < 0 && req_v[j]) idx = j;
            end
        end
        if (idx >= 0) begin
            exp_g[idx] = 1'b1;
            exp_addr = base[idx] + m_off[idx];
        end
        chk("m_gnt", {gnt_wgt1, gnt_wgt, gnt_ifm}, exp_g);
        chk("m_rd_en", mem_rd_en, idx >= 0);
        chk("m_addr", mem_addr, exp_addr);
        chk("m_busy", busy, m_run);
        chk("m_vld", {vld_wgt1, vld_wgt, vld_ifm}, m_vld);
        chk("m_wrap", {wrap_wgt1, wrap_wgt, wrap_ifm}, m_wrap);
        if (m_vld != 0) chk("m_rd_data", rd_data, m_rd);
`ifdef FETCH_STATS_EN
        chk("m_stall_ifm", stall_ifm, m_stall[0]);
        chk("m_stall_wgt", stall_wgt, m_stall[1]);
        chk("m_stall_wgt1", stall_wgt1, m_stall[2]);
`endif
        if (rst_n) begin
            m_vld = exp_g; m_wrap = 0; m_rd = exp_addr[15:0];
            if (idx >= 0) begin
                m_ptr = idx;
                if (m_off[idx] == len[idx] - 1) begin
                    m_off[idx] = 0;
                    m_wrap[idx] = 1'b1;
                end else begin
                    m_off[idx]++;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (start && !abort) m_stall[i] = 0;
                else if (m_run && req_v[i] && !exp_g[i] && m_stall[i] < 64'hFFFF_FFFF) m_stall[i]++;
            end
            if (abort) m_run = 0;
            else if (start) begin
                m_run = 1;
                for (int i = 0; i < 3; i++) m_off[i] = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk2); #1;
    endtask

    task automatic at_mid();
        @(negedge clk2); #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        at_mid();
        step();
        rst_n = 1;
    endtask

    task automatic set_req(input logic i, input logic w, input logic w1);
        req_ifm = i; req_wgt = w; req_wgt1 = w1;
    endtask

    int exp_mix [6] = '{0, 154587, 189435, 1, 154588, 189436};

    initial begin
        rst_n = 0; start = 0; abort = 0;
        set_req(0, 0, 0);
        at_mid();
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_vld", {vld_wgt1, vld_wgt, vld_ifm}, 0);
        chk("rst_wrap", {wrap_wgt1, wrap_wgt, wrap_ifm}, 0);
        step();
        rst_n = 1;

        // Single IFM stream, data returned one cycle later.
        start = 1;
        at_mid();
        chk("t1_start_nogrant", mem_rd_en, 0);
        step();
        start = 0;
        set_req(1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            at_mid();
            chk("t1_gnt_ifm", gnt_ifm, 1);
            chk("t1_addr", mem_addr, k);
            if (k > 0) begin
                chk("t1_vld_ifm", vld_ifm, 1);
                chk("t1_rd_data", rd_data, k - 1);
            end
            step();
        end
        set_req(0, 0, 0);
        at_mid();
        chk("t1_vld_last", vld_ifm, 1);
        chk("t1_rd_last", rd_data, 3);
        chk("t1_gnt_off", gnt_ifm, 0);
        step();

        // All three streams: round-robin order.
        do_reset();
        start = 1;
        step();
        start = 0;
        set_req(1, 1, 1);
        for (int k = 0; k < 6; k++) begin
            at_mid();
            chk("t2_addr", mem_addr, exp_mix[k]);
            chk("t2_gnt", {gnt_wgt1, gnt_wgt, gnt_ifm}, 3'b001 << (k % 3));
            step();
        end
        set_req(0, 0, 0);

        // Weight stream wrap after 4 words.
        start = 1;
        step();
        start = 0;
        for (int k = 0; k < 6; k++) begin
            set_req(0, k < 5, 0);
            at_mid();
            if (k < 5) begin
                chk("t3_gnt_wgt", gnt_wgt, 1);
                chk("t3_addr", mem_addr, 154587 + (k % 4));
            end
            chk("t3_wrap_wgt", wrap_wgt, k == 4);
            step();
        end

        // Abort and start edges.
        do_reset();
        start = 1;
        step();
        start = 0;
        set_req(1, 1, 1);
        at_mid();
        chk("t4_gnt_ifm", gnt_ifm, 1);
        step();
        at_mid();
        chk("t4_gnt_wgt", gnt_wgt, 1);
        step();
        abort = 1;
        at_mid();
        chk("t4_abort_nogrant", mem_rd_en, 0);
        chk("t4_abort_vld_wgt", vld_wgt, 1);
        step();
        abort = 0;
        for (int k = 0; k < 2; k++) begin
            at_mid();
            chk("t4_idle_busy", busy, 0);
            chk("t4_idle_nogrant", mem_rd_en, 0);
            step();
        end
        set_req(1, 0, 0);
        start = 1;
        at_mid();
        chk("t4_start_nogrant", mem_rd_en, 0);
        step();
        start = 0;
        at_mid();
        chk("t4_restart_gnt", gnt_ifm, 1);
        chk("t4_restart_addr", mem_addr, 0);
        step();
        start = 1; abort = 1;
        at_mid();
        chk("t4_both_nogrant", mem_rd_en, 0);
        step();
        start = 0; abort = 0;
        at_mid();
        chk("t4_both_busy", busy, 0);
        chk("t4_both_idle", mem_rd_en, 0);
        step();
        start = 1; abort = 1;
        step();
        start = 0; abort = 0;
        at_mid();
        chk("t4_idle_both_busy", busy, 0);
        step();
        set_req(0, 0, 0);

        // Reset while a read is in flight.
        do_reset();
        start = 1;
        step();
        start = 0;
        set_req(1, 0, 0);
        at_mid();
        chk("t5_gnt", gnt_ifm, 1);
        step();
        rst_n = 0;
        at_mid();
        chk("t5_vld_dropped", vld_ifm, 0);
        chk("t5_busy", busy, 0);
        step();
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            at_mid();
            chk("t5_no_grant", mem_rd_en, 0);
            step();
        end
        start = 1;
        step();
        start = 0;
        at_mid();
        chk("t5_after_start_addr", mem_addr, 0);
        chk("t5_after_start_gnt", gnt_ifm, 1);
        step();
        set_req(0, 0, 0);

`ifdef FETCH_STATS_EN
        // Stall counters over 9 fully contended cycles.
        do_reset();
        start = 1;
        step();
        start = 0;
        set_req(1, 1, 1);
        repeat (9) step();
        set_req(0, 0, 0);
        at_mid();
        chk("t6_stall_ifm", stall_ifm, 6);
        chk("t6_stall_wgt", stall_wgt, 6);
        chk("t6_stall_wgt1", stall_wgt1, 6);
        step();
        start = 1;
        step();
        start = 0;
        at_mid();
        chk("t6_clr_ifm", stall_ifm, 0);
        chk("t6_clr_wgt", stall_wgt, 0);
        chk("t6_clr_wgt1", stall_wgt1, 0);
        step();
`endif

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
